// File: rtl/round_robin_pesado_checker_if.sv
// Bus bundle for the weighted round-robin checker: shared stimulus toward the arbiters
// and the grant outputs of both implementations back toward the bench.
interface round_robin_pesado_checker_if #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int MAX_WEIGHT     = 64,
    parameter int BUF_WIDTH      = 3
);
    localparam int W     = $clog2(MAX_WEIGHT);
    localparam int SEL_W = $clog2(QUEUE_QUANTITY);

    logic                          enb;
    logic [QUEUE_QUANTITY*W-1:0]   pesos;
    logic [QUEUE_QUANTITY-1:0]     buf_empty;
    logic [QUEUE_QUANTITY*BUF_WIDTH-1:0] fifo_counter;
    logic [SEL_W-1:0]              selector;
    logic                          selector_enb;
    logic [SEL_W-1:0]              sint_selector;
    logic                          sint_selector_enb;

    modport master (
        output enb, pesos, buf_empty, fifo_counter,
        input  selector, selector_enb, sint_selector, sint_selector_enb
    );

    modport slave (
        input  enb, pesos, buf_empty, fifo_counter,
        output selector, selector_enb, sint_selector, sint_selector_enb
    );
endinterface

// File: rtl/round_robin_pesado_checker.sv
// Weighted round-robin queue arbiter in two independent formulations (behavioural and
// gate-style) driven by one stimulus, so their grants can be compared cycle by cycle.

module round_robin_pesado #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int W              = 6,
    parameter int SEL_W          = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enb,
    input  logic [QUEUE_QUANTITY*W-1:0] pesos,
    input  logic [QUEUE_QUANTITY-1:0]   buf_empty,
    output logic [SEL_W-1:0]            selector,
    output logic                        selector_enb
);
    logic [W-1:0]     cnt;
    logic [W-1:0]     cur_weight;
    logic             cur_eligible;
    logic             stay;
    logic             found;
    logic [SEL_W-1:0] next_sel;
    int               start_idx;
    int               idx;

    always_comb begin
        cur_weight   = '0;
        cur_eligible = 1'b0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (selector == SEL_W'(i)) begin
                cur_weight   = pesos[i*W +: W];
                cur_eligible = !buf_empty[i];
            end
        end
        if (cur_weight == '0) begin
            cur_weight = W'(1);
        end
        stay = selector_enb && cur_eligible && (cnt < cur_weight - W'(1));
    end

    // Circular search starting just past the current holder, or at it when idle.
    always_comb begin
        found    = 1'b0;
        next_sel = selector;
        idx      = 0;
        if (selector_enb) begin
            start_idx = (int'(selector) + 1) % QUEUE_QUANTITY;
        end else begin
            start_idx = int'(selector);
        end
        for (int k = 0; k < QUEUE_QUANTITY; k++) begin
            idx = (start_idx + k) % QUEUE_QUANTITY;
            if (!found && !buf_empty[idx]) begin
                found    = 1'b1;
                next_sel = SEL_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            selector     <= '0;
            selector_enb <= 1'b0;
            cnt          <= '0;
        end else if (enb) begin
            if (stay) begin
                cnt <= cnt + W'(1);
            end else begin
                selector     <= next_sel;
                selector_enb <= found;
                cnt          <= '0;
            end
        end
    end
endmodule

module round_robin_pesado_sint #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int W              = 6,
    parameter int SEL_W          = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enb,
    input  logic [QUEUE_QUANTITY*W-1:0] pesos,
    input  logic [QUEUE_QUANTITY-1:0]   buf_empty,
    output logic [SEL_W-1:0]            selector,
    output logic                        selector_enb
);
    logic [W-1:0]              cnt;
    logic [QUEUE_QUANTITY-1:0] elig;
    logic [QUEUE_QUANTITY-1:0] cur_onehot;
    logic [QUEUE_QUANTITY-1:0] start_onehot;
    logic [QUEUE_QUANTITY-1:0] mask_hi;
    logic [QUEUE_QUANTITY-1:0] cand_hi;
    logic [QUEUE_QUANTITY-1:0] cand;
    logic [QUEUE_QUANTITY-1:0] pick;
    logic [SEL_W-1:0]          start_sel;
    logic [SEL_W-1:0]          pick_sel;
    logic [W-1:0]              raw_weight;
    logic [W-1:0]              eff_weight;
    logic                      stay;
    logic                      any_elig;

    assign elig     = ~buf_empty;
    assign any_elig = |elig;

    // Weight and eligibility of the holder selected through an AND-OR one-hot mux.
    always_comb begin
        raw_weight = '0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            cur_onehot[i] = (selector == SEL_W'(i));
            raw_weight    = raw_weight | (pesos[i*W +: W] & {W{cur_onehot[i]}});
        end
        eff_weight = raw_weight | {{(W-1){1'b0}}, ~|raw_weight};
        stay = selector_enb && |(cur_onehot & elig)
               && ({1'b0, cnt} + (W+1)'(1) < {1'b0, eff_weight});
    end

    always_comb begin
        if (selector_enb && (selector == SEL_W'(QUEUE_QUANTITY - 1))) begin
            start_sel = '0;
        end else if (selector_enb) begin
            start_sel = selector + SEL_W'(1);
        end else begin
            start_sel = selector;
        end
        for (int j = 0; j < QUEUE_QUANTITY; j++) begin
            start_onehot[j] = (start_sel == SEL_W'(j));
            mask_hi[j]      = (j >= int'(start_sel));
        end
        cand_hi = elig & mask_hi;
        cand    = (|cand_hi) ? cand_hi : elig;
        pick    = cand & (~cand + QUEUE_QUANTITY'(1));
        pick_sel = '0;
        for (int j = 0; j < QUEUE_QUANTITY; j++) begin
            pick_sel = pick_sel | (SEL_W'(j) & {SEL_W{pick[j]}});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            selector     <= '0;
            selector_enb <= 1'b0;
            cnt          <= '0;
        end else if (enb) begin
            if (stay) begin
                cnt <= cnt + W'(1);
            end else if (any_elig) begin
                selector     <= pick_sel;
                selector_enb <= 1'b1;
                cnt          <= '0;
            end else begin
                selector_enb <= 1'b0;
                cnt          <= '0;
            end
        end
    end

    logic unused_start;
    assign unused_start = ^start_onehot;
endmodule

module round_robin_pesado_checker #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8,
    parameter int MAX_WEIGHT     = 64,
    parameter int BUF_WIDTH      = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    round_robin_pesado_checker_if.slave  bus
);
    localparam int W     = $clog2(MAX_WEIGHT);
    localparam int SEL_W = $clog2(QUEUE_QUANTITY);

    if (QUEUE_QUANTITY < 2 || DATA_BITS < 1 || MAX_WEIGHT < 2 || BUF_WIDTH < 1) begin : g_bad_param
        $error("round_robin_pesado_checker: invalid parameter set");
    end

    // Occupancy is reserved for a future policy; the arbiter only looks at buf_empty.
    logic unused_fifo_counter;
    assign unused_fifo_counter = ^bus.fifo_counter;

    round_robin_pesado #(
        .QUEUE_QUANTITY(QUEUE_QUANTITY),
        .W             (W),
        .SEL_W         (SEL_W)
    ) u_rtl (
        .clk         (clk),
        .rst         (rst),
        .enb         (bus.enb),
        .pesos       (bus.pesos),
        .buf_empty   (bus.buf_empty),
        .selector    (bus.selector),
        .selector_enb(bus.selector_enb)
    );

    round_robin_pesado_sint #(
        .QUEUE_QUANTITY(QUEUE_QUANTITY),
        .W             (W),
        .SEL_W         (SEL_W)
    ) u_sint (
        .clk         (clk),
        .rst         (rst),
        .enb         (bus.enb),
        .pesos       (bus.pesos),
        .buf_empty   (bus.buf_empty),
        .selector    (bus.sint_selector),
        .selector_enb(bus.sint_selector_enb)
    );
endmodule

// File: tb/tb_round_robin_pesado_checker.sv
// Directed bench for round_robin_pesado_checker: both grant outputs are compared against
// hand-computed sequences for weighted rotation, empty queues, freeze and reset.
module tb_round_robin_pesado_checker;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    localparam logic [23:0] STD_W  = {6'd6, 6'd3, 6'd2, 6'd1};
    localparam logic [23:0] ZERO_W = 24'd0;

    always #5 clk = ~clk;

    round_robin_pesado_checker_if #(.QUEUE_QUANTITY(4), .MAX_WEIGHT(64), .BUF_WIDTH(3)) bus ();

    round_robin_pesado_checker #(
        .QUEUE_QUANTITY(4), .DATA_BITS(8), .MAX_WEIGHT(64), .BUF_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [23:0] w);
        rst              = 1'b0;
        bus.enb          = 1'b1;
        bus.pesos        = w;
        bus.buf_empty    = 4'b0000;
        bus.fifo_counter = 12'h5A3;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst              = 1'b0;
        bus.enb          = 1'b1;
        bus.pesos        = STD_W;
        bus.buf_empty    = 4'b0000;
        bus.fifo_counter = 12'h000;
        #1;
        checks++;
        if (bus.selector !== 2'd0 || bus.selector_enb !== 1'b0)
            $display("[TB] FAIL reset_rtl sel=%0d en=%0b expected sel=0 en=0", bus.selector, bus.selector_enb);
        checks++;
        if (bus.sint_selector !== 2'd0 || bus.sint_selector_enb !== 1'b0)
            $display("[TB] FAIL reset_sint sel=%0d en=%0b expected sel=0 en=0", bus.sint_selector, bus.sint_selector_enb);
        step();
        step();
        checks++;
        if (bus.selector !== 2'd0 || bus.selector_enb !== 1'b0)
            $display("[TB] FAIL reset_held sel=%0d en=%0b expected sel=0 en=0", bus.selector, bus.selector_enb);
        if (bus.selector !== 2'd0 || bus.selector_enb !== 1'b0) failures++;
    endtask

    task automatic test_weighted_cycle();
        logic [1:0] pat [12] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        do_reset(STD_W);
        bus.fifo_counter = 12'hFFF;
        for (int k = 0; k < 24; k++) begin
            step();
            checks++;
            if (bus.selector !== pat[k % 12] || bus.selector_enb !== 1'b1) begin
                failures++;
                $display("[TB] FAIL weighted_rtl e%0d sel=%0d en=%0b expected sel=%0d en=1", k + 1, bus.selector, bus.selector_enb, pat[k % 12]);
            end
            checks++;
            if (bus.sint_selector !== pat[k % 12] || bus.sint_selector_enb !== 1'b1) begin
                failures++;
                $display("[TB] FAIL weighted_sint e%0d sel=%0d en=%0b expected sel=%0d en=1", k + 1, bus.sint_selector, bus.sint_selector_enb, pat[k % 12]);
            end
        end
    endtask

    task automatic test_empty_pulse();
        logic [1:0] es [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
        do_reset(STD_W);
        for (int k = 0; k < 7; k++) begin
            bus.buf_empty = (k == 2 || k == 6) ? 4'b0011 : 4'b0000;
            step();
            checks++;
            if (bus.selector !== es[k] || bus.selector_enb !== 1'b1) begin
                failures++;
                $display("[TB] FAIL empty_pulse_rtl e%0d sel=%0d en=%0b expected sel=%0d en=1", k + 1, bus.selector, bus.selector_enb, es[k]);
            end
            checks++;
            if (bus.sint_selector !== es[k] || bus.sint_selector_enb !== 1'b1) begin
                failures++;
                $display("[TB] FAIL empty_pulse_sint e%0d sel=%0d en=%0b expected sel=%0d en=1", k + 1, bus.sint_selector, bus.sint_selector_enb, es[k]);
            end
        end
        bus.buf_empty = 4'b0000;
    endtask

    task automatic test_all_empty();
        logic [1:0] es [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        logic       ee [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset(STD_W);
        for (int k = 0; k < 6; k++) begin
            bus.buf_empty = (k == 2) ? 4'b1111 : 4'b0000;
            step();
            checks++;
            if (bus.selector !== es[k] || bus.selector_enb !== ee[k]) begin
                failures++;
                $display("[TB] FAIL all_empty_rtl e%0d sel=%0d en=%0b expected sel=%0d en=%0b", k + 1, bus.selector, bus.selector_enb, es[k], ee[k]);
            end
            checks++;
            if (bus.sint_selector !== es[k] || bus.sint_selector_enb !== ee[k]) begin
                failures++;
                $display("[TB] FAIL all_empty_sint e%0d sel=%0d en=%0b expected sel=%0d en=%0b", k + 1, bus.sint_selector, bus.sint_selector_enb, es[k], ee[k]);
            end
        end
        bus.buf_empty = 4'b0000;
    endtask

    task automatic test_truncate_q3();
        logic [1:0] es [12] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                2'd3, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2};
        do_reset(STD_W);
        for (int k = 0; k < 12; k++) begin
            bus.buf_empty = (k == 8) ? 4'b1000 : 4'b0000;
            step();
            checks++;
            if (bus.selector !== es[k] || bus.selector_enb !== 1'b1) begin
                failures++;
                $display("[TB] FAIL truncate_rtl e%0d sel=%0d en=%0b expected sel=%0d en=1", k + 1, bus.selector, bus.selector_enb, es[k]);
            end
            checks++;
            if (bus.sint_selector !== es[k] || bus.sint_selector_enb !== 1'b1) begin
                failures++;
                $display("[TB] FAIL truncate_sint e%0d sel=%0d en=%0b expected sel=%0d en=1", k + 1, bus.sint_selector, bus.sint_selector_enb, es[k]);
            end
        end
        bus.buf_empty = 4'b0000;
    endtask

    task automatic test_enable_freeze();
        logic [1:0] es [8] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        do_reset(STD_W);
        for (int k = 0; k < 8; k++) step();
        for (int k = 0; k < 8; k++) begin
            bus.enb = (k < 3) ? 1'b0 : 1'b1;
            step();
            checks++;
            if (bus.selector !== es[k] || bus.selector_enb !== 1'b1) begin
                failures++;
                $display("[TB] FAIL freeze_rtl e%0d sel=%0d en=%0b expected sel=%0d en=1", k + 9, bus.selector, bus.selector_enb, es[k]);
            end
            checks++;
            if (bus.sint_selector !== es[k] || bus.sint_selector_enb !== 1'b1) begin
                failures++;
                $display("[TB] FAIL freeze_sint e%0d sel=%0d en=%0b expected sel=%0d en=1", k + 9, bus.sint_selector, bus.sint_selector_enb, es[k]);
            end
        end
        bus.enb = 1'b1;
    endtask

    task automatic test_reset_midturn();
        logic [1:0] es [3] = '{2'd1, 2'd1, 2'd2};
        do_reset(STD_W);
        for (int k = 0; k < 8; k++) step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.selector !== 2'd0 || bus.selector_enb !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midturn_reset_rtl sel=%0d en=%0b expected sel=0 en=0", bus.selector, bus.selector_enb);
        end
        checks++;
        if (bus.sint_selector !== 2'd0 || bus.sint_selector_enb !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midturn_reset_sint sel=%0d en=%0b expected sel=0 en=0", bus.sint_selector, bus.sint_selector_enb);
        end
        bus.buf_empty = 4'b0001;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            bus.buf_empty = 4'b0000;
            checks++;
            if (bus.selector !== es[k] || bus.selector_enb !== 1'b1) begin
                failures++;
                $display("[TB] FAIL after_reset_rtl e%0d sel=%0d en=%0b expected sel=%0d en=1", k + 1, bus.selector, bus.selector_enb, es[k]);
            end
            checks++;
            if (bus.sint_selector !== es[k] || bus.sint_selector_enb !== 1'b1) begin
                failures++;
                $display("[TB] FAIL after_reset_sint e%0d sel=%0d en=%0b expected sel=%0d en=1", k + 1, bus.sint_selector, bus.sint_selector_enb, es[k]);
            end
        end
    endtask

    task automatic test_zero_weight();
        logic [1:0] es [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset(ZERO_W);
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (bus.selector !== es[k] || bus.selector_enb !== 1'b1) begin
                failures++;
                $display("[TB] FAIL zero_weight_rtl e%0d sel=%0d en=%0b expected sel=%0d en=1", k + 1, bus.selector, bus.selector_enb, es[k]);
            end
            checks++;
            if (bus.sint_selector !== es[k] || bus.sint_selector_enb !== 1'b1) begin
                failures++;
                $display("[TB] FAIL zero_weight_sint e%0d sel=%0d en=%0b expected sel=%0d en=1", k + 1, bus.sint_selector, bus.sint_selector_enb, es[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_weighted_cycle();
        test_empty_pulse();
        test_all_empty();
        test_truncate_q3();
        test_enable_freeze();
        test_reset_midturn();
        test_zero_weight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
